axi_sram_if: RTL and testbench
==============================

Name: axi_sram_if

Overview:
AXI3 slave-to-SRAM bridge used as external memory model/adapter for the sa_engine_top master port. It accepts AXI read and write bursts on one shared single-port synchronous SRAM interface. Each D-bit AXI beat is split into R = D/MEM_DW consecutive SRAM words. The SRAM has 1-cycle read latency.

Parameters:
MEM_ADDRW, 23, SRAM word-address width
MEM_DW, 16, SRAM data width; D must be an integer multiple of MEM_DW
A, 32, AXI address width
I, 4, AXI ID width
L, 8, AXI burst-length width
D, 32, AXI data width
M, D/8, write-strobe width

Ports:
ACLK in 1 clock; all logic on rising edge
ARESETn in 1 asynchronous active-low reset
AWID in I; AWADDR in A; AWLEN in L; AWSIZE in 3; AWBURST in 2: write address/control
AWLOCK in 2; AWCACHE in 4; AWPROT in 3: accepted, ignored
AWVALID in 1; AWREADY out 1: write address handshake
WID in I (ignored); WDATA in D; WSTRB in M; WLAST in 1: write data
WVALID in 1; WREADY out 1: write data handshake
BID out I; BRESP out 2; BVALID out 1; BREADY in 1: write response
ARID in I; ARADDR in A; ARLEN in L; ARSIZE in 3; ARBURST in 2: read address/control
ARLOCK in 2; ARCACHE in 4; ARPROT in 3: accepted, ignored
ARVALID in 1; ARREADY out 1: read address handshake
RID out I; RDATA out D; RRESP out 2; RLAST out 1; RVALID out 1; RREADY in 1: read data
mem_addr out MEM_ADDRW SRAM word address
mem_we out 1 SRAM write enable, active high
mem_di out MEM_DW SRAM write data
mem_do in MEM_DW SRAM read data, valid 1 cycle after mem_addr

Behaviour:
- Reset: every output is 0, including all READY/VALID, mem_we, mem_addr, mem_di, RDATA, RID and BID. FSM returns to IDLE. An in-flight burst is abandoned with no response.
- FSM states: IDLE, RD, WR_DATA, WR_MEM, WR_RESP.
- IDLE:
  - ARREADY = 1.
  - AWREADY = 1 only when ARVALID = 0, so reads have priority on simultaneous requests.
  - One address handshake latches ID, address, LEN and BURST, then enters RD or WR_DATA.
- Address mapping:
  - Word address = byte address >> log2(MEM_DW/8), truncated to MEM_ADDRW bits; wraps modulo 2^MEM_ADDRW.
  - Beat b, subword k lives at word base + b*R + k for INCR bursts, or base + k for FIXED bursts.
  - WRAP bursts are treated as INCR.
  - AxSIZE is ignored; full-width transfers are assumed.
- Subword packing is little-endian: subword k occupies DATA[k*MEM_DW +: MEM_DW].
- RD:
  - Issue R consecutive word addresses, one per cycle, and capture mem_do one cycle after each.
  - Then assert RVALID with the assembled RDATA, RID = latched ARID, RRESP = 00.
  - RLAST = 1 on beat index == ARLEN.
  - RDATA, RID and RLAST hold stable while RVALID && !RREADY.
  - On the handshake, fetch the next beat; RVALID drops during the fetch.
  - After the last handshake, return to IDLE.
  - Total beats = ARLEN + 1.
- WR_DATA: assert WREADY; on the WVALID handshake, latch WDATA and WSTRB, deassert WREADY and go to WR_MEM.
- WR_MEM:
  - Over R cycles, drive mem_addr, mem_di = subword k, and mem_we = 1.
  - Subword k is written only if all of its MEM_DW/8 strobe bits are 1; otherwise mem_we = 0 in that cycle.
  - After the beat: go to WR_RESP if it was the last beat (WLAST = 1 or beat count == AWLEN), else return to WR_DATA.
  - A WLAST/count mismatch is resolved by whichever occurs first.
- WR_RESP: BVALID = 1, BID = latched AWID, BRESP = 00, held until BREADY; then return to IDLE.
- Error responses are never generated (always OKAY).
- mem_we is 0 in every state except WR_MEM.
- mem_addr holds its last value when idle.
- Only one transaction is outstanding at a time; the next AR/AW is not accepted until the current one completes.

Test Plan:
- Read, single beat: preload SRAM words 0 = 16'h1234 and 1 = 16'hABCD; ARADDR = 0, ARLEN = 0 -> one beat with RDATA = 32'hABCD1234, RLAST = 1, RID = ARID, RRESP = 0.
- Read burst with backpressure: ARADDR = 8, ARLEN = 3; RREADY toggles every other cycle -> 4 beats from words 4..11, in order; data stable while stalled; RLAST only on the 4th beat.
- Write burst: AWADDR = 16, AWLEN = 1, WDATA = 32'h00020001 then 32'h00040003, WSTRB = 4'hF -> SRAM words 8..11 = 1, 2, 3, 4; BVALID is held until BREADY, with BID = AWID and BRESP = 0.
- Partial strobe: WSTRB = 4'b0011 -> only the low subword is written; the upper word keeps its old value.
- Simultaneous ARVALID and AWVALID in IDLE -> the read is serviced first, then AWREADY asserts.
- Reset mid-burst: assert ARESETn = 0 during an RD with ARLEN = 7 -> all outputs 0 immediately; a new read after reset works correctly.

Source files
------------

// File: rtl/axi_sram_if.sv
// AXI3 slave bridge onto one single-port synchronous SRAM (1-cycle read latency).
// Each AXI beat moves as R consecutive SRAM words; one transaction is in flight at a time.
module axi_sram_if #(
  parameter int MEM_ADDRW = 23,
  parameter int MEM_DW    = 16,
  parameter int A         = 32,
  parameter int I         = 4,
  parameter int L         = 8,
  parameter int D         = 32,
  parameter int M         = D / 8
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [I-1:0]         AWID,
  input  logic [A-1:0]         AWADDR,
  input  logic [L-1:0]         AWLEN,
  input  logic [2:0]           AWSIZE,
  input  logic [1:0]           AWBURST,
  input  logic [1:0]           AWLOCK,
  input  logic [3:0]           AWCACHE,
  input  logic [2:0]           AWPROT,
  input  logic                 AWVALID,
  output logic                 AWREADY,
  input  logic [I-1:0]         WID,
  input  logic [D-1:0]         WDATA,
  input  logic [M-1:0]         WSTRB,
  input  logic                 WLAST,
  input  logic                 WVALID,
  output logic                 WREADY,
  output logic [I-1:0]         BID,
  output logic [1:0]           BRESP,
  output logic                 BVALID,
  input  logic                 BREADY,
  input  logic [I-1:0]         ARID,
  input  logic [A-1:0]         ARADDR,
  input  logic [L-1:0]         ARLEN,
  input  logic [2:0]           ARSIZE,
  input  logic [1:0]           ARBURST,
  input  logic [1:0]           ARLOCK,
  input  logic [3:0]           ARCACHE,
  input  logic [2:0]           ARPROT,
  input  logic                 ARVALID,
  output logic                 ARREADY,
  output logic [I-1:0]         RID,
  output logic [D-1:0]         RDATA,
  output logic [1:0]           RRESP,
  output logic                 RLAST,
  output logic                 RVALID,
  input  logic                 RREADY,
  output logic [MEM_ADDRW-1:0] mem_addr,
  output logic                 mem_we,
  output logic [MEM_DW-1:0]    mem_di,
  input  logic [MEM_DW-1:0]    mem_do
);
  localparam int R     = D / MEM_DW;
  localparam int SB    = MEM_DW / 8;
  localparam int SHIFT = $clog2(SB);
  localparam int SUB_W = $clog2(R + 1);

  typedef enum logic [2:0] {IDLE, RD, WR_DATA, WR_MEM, WR_RESP} state_t;

  state_t               state, state_nxt;
  logic                 alive;
  logic [I-1:0]         id_q;
  logic [MEM_ADDRW-1:0] base_q, addr_q;
  logic [L-1:0]         len_q, beat_q;
  logic                 fixed_q;
  logic [SUB_W-1:0]     sub_q;
  logic [D-1:0]         rdata_q, wdata_q;
  logic [M-1:0]         wstrb_q;
  logic                 wlast_q, rvalid_q;
  logic                 ar_hs, aw_hs, w_hs, sub_end, wr_last;
  logic                 unused_ok;

  // Sideband fields carry no meaning for a flat full-width SRAM.
  assign unused_ok = ^{AWSIZE, AWLOCK, AWCACHE, AWPROT, WID, ARSIZE, ARLOCK, ARCACHE, ARPROT};

  assign ar_hs   = ARVALID && ARREADY;
  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;
  assign sub_end = (sub_q == SUB_W'(R - 1));
  assign wr_last = wlast_q || (beat_q == len_q);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ar_hs) state_nxt = RD;
               else if (aw_hs) state_nxt = WR_DATA;
      RD:      if (RVALID && RREADY && (beat_q == len_q)) state_nxt = IDLE;
      WR_DATA: if (w_hs) state_nxt = WR_MEM;
      WR_MEM:  if (sub_end) state_nxt = wr_last ? WR_RESP : WR_DATA;
      WR_RESP: if (BREADY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read fetch: in step s (0..R) mem_addr shows subword s and mem_do returns subword s-1.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      alive    <= 1'b0;
      id_q     <= '0;
      base_q   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      fixed_q  <= 1'b0;
      sub_q    <= '0;
      rdata_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wlast_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      alive <= 1'b1;
      unique case (state)
        IDLE: begin
          if (ar_hs) begin
            id_q    <= ARID;
            len_q   <= ARLEN;
            fixed_q <= (ARBURST == 2'b00);
            base_q  <= MEM_ADDRW'(ARADDR >> SHIFT);
            addr_q  <= MEM_ADDRW'(ARADDR >> SHIFT);
            beat_q  <= '0;
            sub_q   <= '0;
          end else if (aw_hs) begin
            id_q    <= AWID;
            len_q   <= AWLEN;
            fixed_q <= (AWBURST == 2'b00);
            base_q  <= MEM_ADDRW'(AWADDR >> SHIFT);
            beat_q  <= '0;
          end
        end
        RD: begin
          if (!rvalid_q) begin
            for (int k = 0; k < R; k++)
              if (sub_q == SUB_W'(k + 1)) rdata_q[k*MEM_DW +: MEM_DW] <= mem_do;
            if (sub_q == SUB_W'(R)) begin
              rvalid_q <= 1'b1;
            end else begin
              sub_q <= sub_q + 1'b1;
              if (!sub_end) addr_q <= addr_q + 1'b1;
            end
          end else if (RREADY) begin
            rvalid_q <= 1'b0;
            if (beat_q != len_q) begin
              beat_q <= beat_q + 1'b1;
              sub_q  <= '0;
              addr_q <= fixed_q ? base_q : addr_q + 1'b1;
            end
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            wdata_q <= WDATA;
            wstrb_q <= WSTRB;
            wlast_q <= WLAST;
            sub_q   <= '0;
            addr_q  <= (beat_q == '0 || fixed_q) ? base_q : addr_q + 1'b1;
          end
        end
        WR_MEM: begin
          if (sub_end) begin
            if (!wr_last) beat_q <= beat_q + 1'b1;
          end else begin
            sub_q  <= sub_q + 1'b1;
            addr_q <= addr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // alive keeps the address READYs low while reset is asserted.
  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    ARREADY  = 1'b0;
    AWREADY  = 1'b0;
    WREADY   = 1'b0;
    BVALID   = 1'b0;
    mem_we   = 1'b0;
    mem_di   = '0;
    BID      = id_q;
    BRESP    = 2'b00;
    RID      = id_q;
    RDATA    = rdata_q;
    RRESP    = 2'b00;
    RVALID   = rvalid_q;
    RLAST    = rvalid_q && (beat_q == len_q);
    mem_addr = addr_q;
    unique case (state)
      IDLE: begin
        ARREADY = alive;
        AWREADY = alive && !ARVALID;
      end
      WR_DATA: WREADY = 1'b1;
      WR_RESP: BVALID = 1'b1;
      default: ;
    endcase
    // A subword is written only when all of its strobe bits are set.
    for (int k = 0; k < R; k++) begin
      if (sub_q == SUB_W'(k)) begin
        mem_di = wdata_q[k*MEM_DW +: MEM_DW];
        mem_we = (state == WR_MEM) && (&wstrb_q[k*SB +: SB]);
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_if.sv
// Bench for axi_sram_if: an SRAM on the memory port, a transaction-level reference
// memory producing expected R beats, SRAM word writes and B responses.
`timescale 1ns/1ps
module tb_axi_sram_if;
  localparam int MEM_ADDRW = 23;
  localparam int MEM_DW    = 16;
  localparam int A         = 32;
  localparam int I         = 4;
  localparam int L         = 8;
  localparam int D         = 32;
  localparam int M         = D / 8;
  localparam int R         = D / MEM_DW;
  localparam int TMO       = 200;
  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic [I-1:0] AWID, WID, BID, ARID, RID;
  logic [A-1:0] AWADDR, ARADDR;
  logic [L-1:0] AWLEN, ARLEN;
  logic [2:0] AWSIZE, AWPROT, ARSIZE, ARPROT;
  logic [1:0] AWBURST, AWLOCK, ARBURST, ARLOCK, BRESP, RRESP;
  logic [3:0] AWCACHE, ARCACHE;
  logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [D-1:0] WDATA, RDATA;
  logic [M-1:0] WSTRB;
  logic [MEM_ADDRW-1:0] mem_addr;
  logic mem_we;
  logic [MEM_DW-1:0] mem_di, mem_do;

  always #5 ACLK = ~ACLK;

  axi_sram_if #(.MEM_ADDRW(MEM_ADDRW), .MEM_DW(MEM_DW), .A(A), .I(I), .L(L), .D(D), .M(M)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_di(mem_di), .mem_do(mem_do)
  );

  // Physical SRAM: synchronous write, registered read.
  logic [MEM_DW-1:0] sram [256];
  logic [MEM_DW-1:0] mem_rd = '0;
  always @(posedge ACLK) begin
    if (mem_we) sram[mem_addr[7:0]] <= mem_di;
    mem_rd <= sram[mem_addr[7:0]];
  end
  assign mem_do = mem_rd;

  // Reference model state.
  typedef struct packed { logic [I-1:0] id; logic [D-1:0] data; logic last; } r_exp_t;
  typedef struct packed { logic [MEM_ADDRW-1:0] addr; logic [MEM_DW-1:0] data; } w_exp_t;
  logic [MEM_DW-1:0] ref_mem [256];
  r_exp_t exp_r[$];
  w_exp_t exp_w[$];
  logic [I-1:0] exp_b[$];
  logic [D-1:0] got_r[$];
  logic [D-1:0] wbuf [8];
  logic [M-1:0] sbuf [8];
  logic         lbuf [8];
  int n_cmp = 0;
  int n_bad = 0;
  int r_cnt = 0;
  int b_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [MEM_ADDRW-1:0] waddr(input logic [A-1:0] byte_addr);
    return MEM_ADDRW'(byte_addr / (MEM_DW / 8));
  endfunction

  function automatic logic [MEM_ADDRW-1:0] word_of(input logic [A-1:0] addr, input logic [1:0] burst,
                                                    input int b, input int k);
    int off;
    off = (burst == FIXED) ? k : b * R + k;
    return waddr(addr) + MEM_ADDRW'(off);
  endfunction

  function automatic void model_read(input logic [I-1:0] id, input logic [A-1:0] addr,
                                     input int len, input logic [1:0] burst);
    for (int b = 0; b <= len; b++) begin
      r_exp_t e;
      logic [MEM_ADDRW-1:0] a;
      e.id   = id;
      e.last = (b == len);
      e.data = '0;
      for (int k = 0; k < R; k++) begin
        a = word_of(addr, burst, b, k);
        e.data[k*MEM_DW +: MEM_DW] = ref_mem[a[7:0]];
      end
      exp_r.push_back(e);
    end
  endfunction

  function automatic void model_write(input logic [I-1:0] id, input logic [A-1:0] addr,
                                      input logic [1:0] burst, input int nb);
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < R; k++) begin
        w_exp_t w;
        w.addr = word_of(addr, burst, b, k);
        w.data = wbuf[b][k*MEM_DW +: MEM_DW];
        if (&sbuf[b][k*(MEM_DW/8) +: MEM_DW/8]) begin
          ref_mem[w.addr[7:0]] = w.data;
          exp_w.push_back(w);
        end
      end
    end
    exp_b.push_back(id);
  endfunction

  // Single compare process, sampled on the falling edge.
  logic         stall_prev = 1'b0;
  logic [D+I:0] r_prev = '0;
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("r_hold_valid", RVALID, 1'b1);
        check("r_hold_data", {RID, RLAST, RDATA}, r_prev);
      end
      if (RVALID && RREADY) begin
        check("r_beat_expected", exp_r.size() != 0, 1'b1);
        if (exp_r.size() != 0) begin
          r_exp_t e;
          e = exp_r.pop_front();
          check("r_data", RDATA, e.data);
          check("r_id", RID, e.id);
          check("r_last", RLAST, e.last);
          check("r_resp", RRESP, 2'b00);
        end
        got_r.push_back(RDATA);
        r_cnt++;
      end
      stall_prev = RVALID && !RREADY;
      r_prev     = {RID, RLAST, RDATA};
      if (mem_we) begin
        check("mem_write_expected", exp_w.size() != 0, 1'b1);
        if (exp_w.size() != 0) begin
          w_exp_t w;
          w = exp_w.pop_front();
          check("mem_addr", mem_addr, w.addr);
          check("mem_di", mem_di, w.data);
        end
      end
      if (BVALID && BREADY) begin
        check("b_expected", exp_b.size() != 0, 1'b1);
        if (exp_b.size() != 0) check("b_id", BID, exp_b.pop_front());
        check("b_resp", BRESP, 2'b00);
        b_cnt++;
      end
    end
  end

  logic [127:0] all_out;
  assign all_out = 128'({AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP,
                         RLAST, RVALID, mem_addr, mem_we, mem_di});

  task automatic ar_phase(input logic [I-1:0] id, input logic [A-1:0] addr, input int len,
                          input logic [1:0] burst);
    int n;
    ARID = id; ARADDR = addr; ARLEN = L'(len); ARBURST = burst; ARVALID = 1'b1;
    model_read(id, addr, len, burst);
    n = 0;
    do begin @(negedge ACLK); n++; end while (!ARREADY && n < TMO);
    check("ar_accept", ARREADY, 1'b1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
  endtask

  task automatic r_phase(input int len, input bit toggle);
    int tgt, cyc;
    tgt = r_cnt + len + 1;
    cyc = 0;
    while (r_cnt < tgt && cyc < TMO) begin
      RREADY = toggle ? (cyc % 2 == 1) : 1'b1;
      @(posedge ACLK); #1;
      cyc++;
    end
    RREADY = 1'b0;
    check("r_beat_count", r_cnt, tgt);
    check("r_queue_drained", exp_r.size(), 0);
  endtask

  task automatic aw_phase(input logic [I-1:0] id, input logic [A-1:0] addr, input int len,
                          input logic [1:0] burst, input int nb);
    int n;
    AWID = id; AWADDR = addr; AWLEN = L'(len); AWBURST = burst; AWVALID = 1'b1;
    model_write(id, addr, burst, nb);
    n = 0;
    do begin @(negedge ACLK); n++; end while (!AWREADY && n < TMO);
    check("aw_accept", AWREADY, 1'b1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
  endtask

  task automatic w_phase(input int nb);
    int n;
    for (int b = 0; b < nb; b++) begin
      WDATA = wbuf[b]; WSTRB = sbuf[b]; WLAST = lbuf[b]; WVALID = 1'b1;
      n = 0;
      do begin @(negedge ACLK); n++; end while (!WREADY && n < TMO);
      check("w_accept", WREADY, 1'b1);
      @(posedge ACLK); #1;
      WVALID = 1'b0; WLAST = 1'b0;
    end
  endtask

  task automatic b_phase();
    int n, tgt;
    tgt = b_cnt + 1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!BVALID && n < TMO);
    check("b_valid", BVALID, 1'b1);
    for (int h = 0; h < 2; h++) begin
      @(negedge ACLK);
      check("b_hold", BVALID, 1'b1);
    end
    @(posedge ACLK); #1;
    BREADY = 1'b1;
    n = 0;
    while (b_cnt < tgt && n < TMO) begin @(posedge ACLK); #1; n++; end
    BREADY = 1'b0;
    check("b_count", b_cnt, tgt);
    check("w_queue_drained", exp_w.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n, tgt;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = INCR; AWLOCK = '0;
    AWCACHE = '0; AWPROT = '0; AWVALID = 1'b0; WID = '0; WDATA = '0; WSTRB = '0;
    WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0;
    ARSIZE = 3'd2; ARBURST = INCR; ARLOCK = '0; ARCACHE = '0; ARPROT = '0;
    ARVALID = 1'b0; RREADY = 1'b0;
    for (int i = 0; i < 256; i++) begin
      sram[i]    = 16'hA000 + 16'(i);
      ref_mem[i] = 16'hA000 + 16'(i);
    end
    sram[0] = 16'h1234; ref_mem[0] = 16'h1234;
    sram[1] = 16'hABCD; ref_mem[1] = 16'hABCD;

    repeat (3) @(posedge ACLK);
    #1;
    check("reset_outputs", all_out, 128'h0);
    ARESETn = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;

    // Single-beat read.
    got_r.delete();
    ar_phase(4'h3, 32'h0, 0, INCR);
    r_phase(0, 1'b0);
    check("t1_rdata", got_r[0], 32'hABCD1234);

    // Four-beat read with RREADY toggling.
    got_r.delete();
    ar_phase(4'h5, 32'h8, 3, INCR);
    r_phase(3, 1'b1);
    check("t2_beats", got_r.size(), 4);
    check("t2_first", got_r[0], 32'hA005A004);
    check("t2_last", got_r[3], 32'hA00BA00A);

    // Two-beat full-strobe write.
    wbuf[0] = 32'h00020001; sbuf[0] = 4'hF; lbuf[0] = 1'b0;
    wbuf[1] = 32'h00040003; sbuf[1] = 4'hF; lbuf[1] = 1'b1;
    aw_phase(4'h9, 32'h10, 1, INCR, 2);
    w_phase(2);
    b_phase();
    check("t3_w8", sram[8], 16'h0001);
    check("t3_w9", sram[9], 16'h0002);
    check("t3_w10", sram[10], 16'h0003);
    check("t3_w11", sram[11], 16'h0004);

    // Partial strobe: low subword only.
    wbuf[0] = 32'h55556666; sbuf[0] = 4'b0011; lbuf[0] = 1'b1;
    aw_phase(4'h2, 32'h18, 0, INCR, 1);
    w_phase(1);
    b_phase();
    check("t4_low", sram[12], 16'h6666);
    check("t4_high_kept", sram[13], 16'hA00D);

    // Simultaneous AR/AW: read first.
    got_r.delete();
    ARID = 4'h6; ARADDR = 32'h10; ARLEN = '0; ARBURST = INCR; ARVALID = 1'b1;
    AWID = 4'h7; AWADDR = 32'h28; AWLEN = '0; AWBURST = INCR; AWVALID = 1'b1;
    model_read(4'h6, 32'h10, 0, INCR);
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF; lbuf[0] = 1'b1;
    model_write(4'h7, 32'h28, INCR, 1);
    n = 0;
    do begin @(negedge ACLK); n++; end while (!ARREADY && n < TMO);
    check("t5_ar_accept", ARREADY, 1'b1);
    check("t5_aw_blocked", AWREADY, 1'b0);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    tgt = r_cnt + 1;
    RREADY = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!AWREADY && n < TMO);
    check("t5_aw_accept", AWREADY, 1'b1);
    check("t5_read_first", r_cnt, tgt);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; RREADY = 1'b0;
    w_phase(1);
    b_phase();
    check("t5_rdata", got_r[0], 32'h00020001);
    check("t5_w20", sram[20], 16'hBEEF);
    check("t5_w21", sram[21], 16'hDEAD);

    // Early WLAST on an AWLEN=3 burst, second beat with a split strobe.
    wbuf[0] = 32'h11112222; sbuf[0] = 4'hF;    lbuf[0] = 1'b0;
    wbuf[1] = 32'h33334444; sbuf[1] = 4'b0111; lbuf[1] = 1'b1;
    aw_phase(4'hA, 32'h30, 3, INCR, 2);
    w_phase(2);
    b_phase();
    check("t6_w26", sram[26], 16'h4444);
    check("t6_w27_kept", sram[27], 16'hA01B);
    got_r.delete();
    ar_phase(4'hB, 32'h30, 1, INCR);
    r_phase(1, 1'b1);
    check("t6_readback", got_r[0], 32'h11112222);

    // FIXED burst re-reads the same two words.
    got_r.delete();
    ar_phase(4'hC, 32'h0, 2, FIXED);
    r_phase(2, 1'b0);
    for (int b = 0; b < 3; b++) check("t7_fixed", got_r[b], 32'hABCD1234);

    // Reset in the middle of an eight-beat read.
    ar_phase(4'hD, 32'h40, 7, INCR);
    tgt = r_cnt + 2;
    RREADY = 1'b1;
    n = 0;
    while (r_cnt < tgt && n < TMO) begin @(posedge ACLK); #1; n++; end
    check("t8_progress", r_cnt, tgt);
    ARESETn = 1'b0;
    #1;
    check("t8_reset_outputs", all_out, 128'h0);
    RREADY = 1'b0;
    exp_r.delete();
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    got_r.delete();
    ar_phase(4'hE, 32'h0, 0, INCR);
    r_phase(0, 1'b0);
    check("t8_after_reset", got_r[0], 32'hABCD1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
